// File: rtl/secded64_pkg.sv
// Shared SEC-DED (72,64) definitions: widths, H-matrix columns and check/parity helpers.
// Used by both the encoder pipeline and the matching decoder.
package secded64_pkg;

    localparam int DATA_W = 64;
    localparam int CHK_W  = 7;
    localparam int CODE_W = 72;

    // Column i is the (i+1)-th 7-bit value that is neither zero nor a power of two.
    localparam logic [CHK_W-1:0] H_COL [0:DATA_W-1] = '{
        7'd3,  7'd5,  7'd6,  7'd7,  7'd9,  7'd10, 7'd11, 7'd12,
        7'd13, 7'd14, 7'd15, 7'd17, 7'd18, 7'd19, 7'd20, 7'd21,
        7'd22, 7'd23, 7'd24, 7'd25, 7'd26, 7'd27, 7'd28, 7'd29,
        7'd30, 7'd31, 7'd33, 7'd34, 7'd35, 7'd36, 7'd37, 7'd38,
        7'd39, 7'd40, 7'd41, 7'd42, 7'd43, 7'd44, 7'd45, 7'd46,
        7'd47, 7'd48, 7'd49, 7'd50, 7'd51, 7'd52, 7'd53, 7'd54,
        7'd55, 7'd56, 7'd57, 7'd58, 7'd59, 7'd60, 7'd61, 7'd62,
        7'd63, 7'd65, 7'd66, 7'd67, 7'd68, 7'd69, 7'd70, 7'd71
    };

    // Payload held in the first pipeline stage.
    typedef struct packed {
        logic [CODE_W-1:0] inj;
        logic [CHK_W-1:0]  chk;
        logic [DATA_W-1:0] data;
    } s1_word_t;

    function automatic logic [CHK_W-1:0] secded64_chk(input logic [DATA_W-1:0] data);
        logic [CHK_W-1:0] chk_s;
        chk_s = {CHK_W{1'b0}};
        for (int j = 0; j < CHK_W; j++) begin
            for (int i = 0; i < DATA_W; i++) begin
                chk_s[j] = chk_s[j] ^ (data[i] & H_COL[i][j]);
            end
        end
        return chk_s;
    endfunction

    function automatic logic secded64_par(input logic [DATA_W-1:0] data,
                                          input logic [CHK_W-1:0]  chk);
        return ^{chk, data};
    endfunction

endpackage

// File: rtl/sec_ded_enc64_pipe_if.sv
// Valid/ready bus of the SEC-DED encoder: data/mask in, codeword out.
interface sec_ded_enc64_pipe_if;
    import secded64_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CODE_W-1:0] in_inj;
    logic              out_valid;
    logic              out_ready;
    logic [CODE_W-1:0] out_code;

    modport master (
        output in_valid, in_data, in_inj, out_ready,
        input  in_ready, out_valid, out_code
    );

    modport slave (
        input  in_valid, in_data, in_inj, out_ready,
        output in_ready, out_valid, out_code
    );

endinterface

// File: rtl/secded64_pstage.sv
// Generic valid/ready pipeline register; ready is combinational from downstream,
// so a full stage can be refilled in the same cycle it is drained.
module secded64_pstage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         v_r;
    logic [W-1:0] data_r;
    logic         rdy_s;
    logic         load_s;

    // Accept when empty or when the held word leaves this cycle.
    always_comb begin
        rdy_s  = !v_r || out_ready;
        load_s = in_valid && rdy_s;
    end

    // Stage valid flag and payload register.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_r    <= 1'b0;
            data_r <= {W{1'b0}};
        end else if (load_s) begin
            v_r    <= 1'b1;
            data_r <= in_data;
        end else if (out_ready) begin
            v_r    <= 1'b0;
            data_r <= data_r;
        end else begin
            v_r    <= v_r;
            data_r <= data_r;
        end
    end

    assign in_ready  = rdy_s;
    assign out_valid = v_r;
    assign out_data  = data_r;

endmodule

// File: rtl/sec_ded_enc64_pipe.sv
// Two-stage SEC-DED (72,64) encoder: S1 holds data, check bits and mask; S2 holds the
// finished, optionally fault-injected codeword. Also counts delivered codewords.
module sec_ded_enc64_pipe
    import secded64_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    sec_ded_enc64_pipe_if.slave  bus,
    output logic [CNT_W-1:0]     word_cnt
);

    localparam int S1_W = $bits(s1_word_t);

    s1_word_t          s1_in_s;
    s1_word_t          s1_out_s;
    logic              s1_rdy_s;
    logic              s1_v_s;
    logic              s2_rdy_s;
    logic              s2_v_s;
    logic              par_s;
    logic [CODE_W-1:0] code_s;
    logic [CODE_W-1:0] s2_code_s;
    logic [CNT_W-1:0]  cnt_r;

    // Check bits are formed before S1 so S2 only has parity and masking left.
    always_comb begin
        s1_in_s.inj  = bus.in_inj;
        s1_in_s.chk  = secded64_chk(bus.in_data);
        s1_in_s.data = bus.in_data;
    end

    // Overall parity over the clean word, then the mask flips the requested bits.
    always_comb begin
        par_s  = secded64_par(s1_out_s.data, s1_out_s.chk);
        code_s = {par_s, s1_out_s.chk, s1_out_s.data} ^ s1_out_s.inj;
    end

    secded64_pstage #(.W(S1_W)) u_s1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (bus.in_valid),
        .in_ready  (s1_rdy_s),
        .in_data   (s1_in_s),
        .out_valid (s1_v_s),
        .out_ready (s2_rdy_s),
        .out_data  (s1_out_s)
    );

    secded64_pstage #(.W(CODE_W)) u_s2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_v_s),
        .in_ready  (s2_rdy_s),
        .in_data   (code_s),
        .out_valid (s2_v_s),
        .out_ready (bus.out_ready),
        .out_data  (s2_code_s)
    );

    // Delivered-codeword counter, wraps silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (s2_v_s && bus.out_ready) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign bus.in_ready  = s1_rdy_s;
    assign bus.out_valid = s2_v_s;
    assign bus.out_code  = s2_code_s;
    assign word_cnt      = cnt_r;

endmodule

// File: tb/tb_sec_ded_enc64_pipe.sv
// Scoreboard bench for sec_ded_enc64_pipe: directed cases plus 1000 random words
// checked against a behavioural extended-Hamming encoder/decoder.
module tb_sec_ded_enc64_pipe;

    typedef struct {
        logic [71:0] code;
        logic [63:0] data;
        logic [71:0] inj;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] word_cnt;
    exp_t        q[$];
    int          n_checks = 0;
    int          n_err    = 0;
    logic [6:0]  hcol [64];
    logic [31:0] cnt_model = 32'd0;
    bit          rdy_rand  = 1'b0;
    logic        rdy_force = 1'b1;

    sec_ded_enc64_pipe_if bus ();

    sec_ded_enc64_pipe #(.CNT_W(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .word_cnt (word_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // Reference encoder: XOR together the H columns of every set data bit.
    function automatic logic [71:0] model_enc(input logic [63:0] d, input logic [71:0] inj);
        logic [6:0] c;
        logic       p;
        c = 7'd0;
        for (int i = 0; i < 64; i++) begin
            if (d[i]) c = c ^ hcol[i];
        end
        p = ($countones({c, d}) % 2) == 1;
        return {p, c, d} ^ inj;
    endfunction

    function automatic logic [6:0] model_syn(input logic [71:0] code);
        logic [6:0] c;
        c = 7'd0;
        for (int i = 0; i < 64; i++) begin
            if (code[i]) c = c ^ hcol[i];
        end
        return c ^ code[70:64];
    endfunction

    function automatic logic [71:0] rand_inj();
        logic [95:0] t;
        int a;
        int b;
        case ($urandom_range(0, 3))
            0: return 72'h0;
            1: return 72'h1 << $urandom_range(0, 71);
            2: begin
                a = $urandom_range(0, 71);
                b = (a + 1 + $urandom_range(0, 70)) % 72;
                return (72'h1 << a) | (72'h1 << b);
            end
            default: begin
                t = {$urandom, $urandom, $urandom};
                return t[71:0];
            end
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one word; the expected codeword is queued when the handshake is seen.
    task automatic send(input logic [63:0] d, input logic [71:0] inj, input logic [71:0] exp);
        exp_t e;
        bit   acc;
        int   t;
        e.code = exp;
        e.data = d;
        e.inj  = inj;
        acc = 1'b0;
        t = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_inj   = inj;
        while (!acc && t < 100) begin
            @(negedge clk);
            if (bus.in_ready && !rst) begin
                q.push_back(e);
                acc = 1'b1;
            end
            @(posedge clk);
            #1;
            t++;
        end
        bus.in_valid = 1'b0;
        chk("send_accept", acc, 1'b1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 300) begin
            step();
            t++;
        end
        chk("drain_empty", q.size() == 0, 1'b1);
        step();
    endtask

    // Downstream ready: either forced by the directed tests or randomised.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            bus.out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
        end
    end

    // Monitor: compares every delivered codeword and the counter with the scoreboard.
    initial begin
        exp_t       e;
        logic [6:0] syn;
        logic       sgl;
        logic       dbl;
        logic [63:0] corr;
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                cnt_model = 32'd0;
            end else begin
                chk("word_cnt", word_cnt, cnt_model);
                if (bus.out_valid) begin
                    if (q.size() == 0) begin
                        n_checks++;
                        n_err++;
                        $display("FAIL unexpected_out: actual %h required no word", bus.out_code);
                    end else if (bus.out_ready) begin
                        e = q.pop_front();
                        chk("out_code", bus.out_code, e.code);
                        syn = model_syn(bus.out_code);
                        sgl = ($countones(bus.out_code) % 2) == 1;
                        dbl = !sgl && (syn != 7'd0);
                        corr = bus.out_code[63:0];
                        if (sgl) begin
                            for (int i = 0; i < 64; i++) begin
                                if (hcol[i] == syn) corr[i] = ~corr[i];
                            end
                        end
                        if ($countones(e.inj) == 1) begin
                            chk("dec_sgl", {sgl, dbl, corr}, {1'b1, 1'b0, e.data});
                        end else if ($countones(e.inj) == 2) begin
                            chk("dec_dbl", {sgl, dbl}, 2'b01);
                        end
                        cnt_model = cnt_model + 32'd1;
                    end else begin
                        chk("stall_hold", bus.out_code, q[0].code);
                    end
                end
            end
        end
    end

    initial begin
        logic [63:0] d;
        logic [71:0] inj;
        int k;
        k = 0;
        for (int v = 1; v < 128 && k < 64; v++) begin
            if ((v & (v - 1)) != 0) begin
                hcol[k] = v[6:0];
                k++;
            end
        end

        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 64'h0;
        bus.in_inj   = 72'h0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_code", bus.out_code, 72'h0);
        chk("rst_word_cnt", word_cnt, 32'd0);
        chk("rst_in_ready", bus.in_ready, 1'b1);

        // Latency of two cycles for an all-zero word.
        step();
        send(64'h0, 72'h0, 72'h0);
        @(negedge clk);
        chk("lat_cycle1", bus.out_valid, 1'b0);
        @(negedge clk);
        chk("lat_cycle2", bus.out_valid, 1'b1);
        step();
        send(64'h1, 72'h0, 72'h83_0000_0000_0000_0001);
        send(64'h2, 72'h0, 72'h85_0000_0000_0000_0002);
        send(64'h1, 72'h1, 72'h83_0000_0000_0000_0000);
        drain();
        chk("dir_cnt", word_cnt, 32'd4);

        // Reset with both stages full, with a word offered in the reset cycle.
        rdy_force = 1'b0;
        step();
        send(64'hA5A5_A5A5_0F0F_0F0F, 72'h0, model_enc(64'hA5A5_A5A5_0F0F_0F0F, 72'h0));
        send(64'h1234_5678_9ABC_DEF0, 72'h0, model_enc(64'h1234_5678_9ABC_DEF0, 72'h0));
        chk("full_in_ready", bus.in_ready, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 64'hDEAD_BEEF_DEAD_BEEF;
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        chk("mid_rst_valid", bus.out_valid, 1'b0);
        chk("mid_rst_code", bus.out_code, 72'h0);
        chk("mid_rst_cnt", word_cnt, 32'd0);
        chk("mid_rst_ready", bus.in_ready, 1'b1);
        rdy_force = 1'b1;
        repeat (6) step();
        chk("mid_rst_no_stale", word_cnt, 32'd0);

        // Backpressure: two words fill the pipe, then the output stalls.
        rdy_force = 1'b0;
        step();
        send(64'h0000_0000_0000_0004, 72'h0, model_enc(64'h4, 72'h0));
        send(64'hFFFF_FFFF_FFFF_FFFF, 72'h0, model_enc(64'hFFFF_FFFF_FFFF_FFFF, 72'h0));
        chk("bp_in_ready", bus.in_ready, 1'b0);
        repeat (5) step();
        chk("bp_hold", bus.out_code, model_enc(64'h4, 72'h0));
        rdy_force = 1'b1;
        send(64'h8000_0000_0000_0000, 72'h0, model_enc(64'h8000_0000_0000_0000, 72'h0));
        send(64'h0123_4567_89AB_CDEF, 72'h0, model_enc(64'h0123_4567_89AB_CDEF, 72'h0));
        drain();
        chk("bp_cnt", word_cnt, 32'd4);

        // Random traffic with random downstream stalls.
        rdy_rand = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            if ($urandom_range(0, 3) == 0) step();
            d   = {$urandom, $urandom};
            inj = rand_inj();
            send(d, inj, model_enc(d, inj));
        end
        drain();
        rdy_rand = 1'b0;
        step();
        chk("rand_cnt", word_cnt, 32'd1004);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/sec_ded_enc64_pipe.md
# sec_ded_enc64_pipe

Pipelined SEC-DED (72,64) encoder, the transmit-side counterpart of the decoder64 block. It accepts 64-bit data words over a valid/ready handshake and produces 72-bit codewords of extended-Hamming form, each with 7 check bits and 1 overall-parity bit. A per-word error-injection mask lets benches and built-in self-test feed the decoder with known single-bit and double-bit faults. A transfer counter reports how many codewords have been delivered.

## Interface
Parameters:
- `CNT_W`, 32: width of the delivered-word counter.

Ports (clock and reset first):
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: `in_data` and `in_inj` are valid.
- `in_ready` out 1: encoder accepts the word this cycle.
- `in_data` in 64: data word.
- `in_inj` in 72: error-injection mask. It travels with the word and is XORed into the finished codeword.
- `out_valid` out 1: `out_code` is valid.
- `out_ready` in 1: downstream consumes `out_code` this cycle.
- `out_code` out 72: codeword. [63:0] = data, [70:64] = check bits c6..c0, [71] = overall parity.
- `word_cnt` out CNT_W: number of output transfers since reset; wraps modulo 2^CNT_W.

## Operation
- H-matrix column for data bit i, `H_COL[i]` (7 bits): the (i+1)-th value in ascending order of the 7-bit integers that are neither zero nor a power of two. So bit0→3, bit1→5, bit2→6, bit3→7, bit4→9, and so on.
- Check bits: c_j = XOR of all `in_data[i]` for which `H_COL[i][j]` = 1, for j = 0..6.
- Overall parity p = XOR of the 64 data bits and the 7 check bits. The unmasked 72-bit word therefore has even parity.
- Final codeword: `out_code` = {p, c6..c0, data} XOR `in_inj`.
- Stage 1 (S1):
  - registers data, the 7 check bits and the injection mask;
  - `s1_v` is the stage valid flag.
- Stage 2 (S2):
  - computes p from the S1 contents;
  - applies the mask;
  - registers `out_code`;
  - `s2_v` drives `out_valid`.
- Handshake:
  - Transfer occurs on any cycle where valid and ready are both high.
  - S2 loads when `s1_v` and (!`s2_v` or `out_ready`).
  - `in_ready` = !`s1_v` or (!`s2_v` or `out_ready`). This ready path is combinational; there is no skid buffer.
- `word_cnt` increments by 1 on each cycle with `out_valid` and `out_ready` both high.

## Timing
- Latency is 2 cycles from input transfer to `out_valid`, provided there is no backpressure.
- Throughput is 1 word per cycle while `out_ready` stays high.
- Reset values:
  - `s1_v`, `s2_v`, `out_valid` = 0;
  - `out_code` = 0;
  - `word_cnt` = 0;
  - `in_ready` = 1 during the first cycle after reset deasserts.
- Asserting `rst` mid-stream discards both in-flight words and clears the counter on the same edge. An input offered in that cycle is not accepted.
- While `out_valid` is high and `out_ready` is low, `out_code` holds stable and S2 does not reload.
  - S1 keeps accepting one more word, then `in_ready` drops.
- Simultaneous output consume and S1→S2 advance is allowed in the same cycle; no bubble is inserted.
- Counter wrap: the increment from all-ones produces 0; no flag is raised.
- Data must not be corrupted while stalled. A mask value travels only with its own word.

## Structure
- Shared package `secded64_pkg`:
  - `DATA_W`=64, `CHK_W`=7, `CODE_W`=72;
  - `H_COL` as a 64-entry constant array;
  - function `secded64_chk(data)` returning the 7 check bits.
  - The decoder reuses this package for syndrome decoding.
- One sub-module, `secded64_pstage`: a generic valid/ready pipeline register, instantiated twice.
- The top level holds the combinational check-bit, parity and mask logic plus the counter.

## Test plan
- Data 0, mask 0 → `out_code` = 72'h0; appears 2 cycles after transfer; `word_cnt` = 1.
- Data 64'h1, mask 0 → 72'h83_0000000000000001. Data 64'h2 → 72'h85_0000000000000002.
- Data 64'h1, mask = 72'h1 → 72'h83_0000000000000000, a single-bit fault. Feeding this into the decoder yields SGL=1, DBL=0, corrected data 64'h1.
- Backpressure case:
  - Stream 4 words with `out_ready` = 0 for 5 cycles.
  - → `in_ready` falls after 2 accepted words.
  - `out_code` stays fixed while stalled.
  - All 4 words then emerge in order when ready returns.
  - `word_cnt` = 4.
- Assert `rst` with both stages full → next cycle `out_valid` = 0 and `word_cnt` = 0. No stale word appears afterwards.
- Random 1000 words with random `out_ready`, comparing against a reference model:
  - every codeword matches the model;
  - masks of weight 2 give DBL=1 at the decoder.
